tick_scheduler: RTL and testbench
=================================

# tick_scheduler

Programmable tick scheduler that shares one prescaler counter among N_CH timing channels. Each channel emits single-cycle enable pulses at its own configured multiple of the base tick. Blocks downstream (display scanners, debouncers, blinkers) use these enables instead of a separately divided clock per consumer. Channel periods and enables are written at runtime through a valid/ready configuration port sequenced by a small FSM.

## Interface
- PRESCALE, default 100: clk_in cycles per base tick; must be ≥ 2.
- N_CH, default 4: number of channels; must be ≥ 1.
- PERIOD_W, default 16: width of the channel period field.
- clk_in, input, 1: sole clock; all logic on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- run, input, 1: global enable for the prescaler and channel counters.
- cfg_valid, input, 1: configuration request.
- cfg_ready, output, 1: the block can accept a configuration this cycle.
- cfg_ch, input, max(1,$clog2(N_CH)): target channel index.
- cfg_period, input, PERIOD_W: channel period, in base ticks.
- cfg_en, input, 1: channel enable.
- cfg_err, output, 1: one-cycle pulse when an accepted request is invalid.
- base_tick, output, 1: one-cycle pulse every PRESCALE running cycles.
- tick, output, N_CH: per-channel one-cycle pulses.

## Operation
- Prescaler, pcnt, width $clog2(PRESCALE):
  - When run=1, it counts 0..PRESCALE-1 and wraps to 0.
  - When run=0, it holds its value.
  - The internal tick bt is asserted when run=1 and pcnt==PRESCALE-1.
- Channel i state: period[i], en[i], ccnt[i], with ccnt[i] the same width as the period field.
  - On bt with en[i]=1: if ccnt[i]==period[i]-1, then ccnt[i] goes to 0 and tick[i] fires. Otherwise ccnt[i] increments.
  - A channel with en[i]=0 holds ccnt[i] at 0 and never ticks.
- Configuration FSM, two states:
  - IDLE: cfg_ready=1. On cfg_valid=1, latch cfg_ch/cfg_period/cfg_en and go to APPLY.
  - APPLY: cfg_ready=0. Write the channel fields, clear ccnt[ch], then return to IDLE. APPLY lasts exactly one cycle.
  - Throughput: one accepted request every 2 cycles.
- Invalid request, either cfg_ch ≥ N_CH or cfg_period == 0:
  - It is still consumed normally through IDLE→APPLY.
  - cfg_err pulses during the APPLY cycle.
  - For period 0 with a valid channel: period is written as 0 and en forced to 0.
  - For an out-of-range cfg_ch: no channel state changes.
- Period 1 means the channel ticks on every bt.
- Collision: if APPLY writes channel i in the same cycle that bt occurs, the write wins. tick[i] does not fire that cycle and ccnt[i]=0 afterwards. Other channels are unaffected.
- The prescaler is never reset by configuration, so channel phases stay aligned to the shared base tick.

## Timing
- Reset values, in the first cycle after reset is sampled high:
  - Outputs: cfg_ready=0, cfg_err=0, base_tick=0, tick=0.
  - Internal: pcnt=0, all period/en/ccnt=0, FSM=IDLE.
  - cfg_ready becomes 1 one cycle after reset deasserts.
- Reset mid-APPLY aborts the write. A request in flight is lost.
- Outputs are registered. base_tick and tick[i] go high one cycle after the clk_in edge on which bt was computed, and are high for exactly one cycle. tick[i] is always coincident with base_tick.
- Start-up: with run held at 1 from reset release, the first base_tick is at cycle PRESCALE. Cycles count from 1, the first edge with run=1. After that, base_tick repeats every PRESCALE cycles.
- Channel i, configured with period P and enabled, ticks on every P-th base_tick after its APPLY cycle.
- When run drops, pcnt and ccnt freeze and no pulses occur. When run is reasserted, counting resumes from the frozen values.
- cfg_err is high in the APPLY cycle itself. It is not delayed by the output register stage.

## Test plan
- Reset then run=1, PRESCALE=4: base_tick pulses at cycles 4, 8, 12; all tick bits stay 0; cfg_ready=1 from cycle 1.
- Configure ch0 P=1, ch1 P=3, both enabled, PRESCALE=4:
  - tick[0] fires on every base_tick.
  - tick[1] fires on the 3rd, 6th, … base_tick after its APPLY.
- Back-to-back cfg_valid held high for 4 requests: cfg_ready toggles 1,0,1,0, each request is accepted once, and all four channels are programmed.
- Invalid requests:
  - cfg_period=0 on ch2: cfg_err pulses once and ch2 never ticks.
  - cfg_ch=5 with N_CH=4: cfg_err pulses once and no channel changes.
- Collision: time APPLY on ch1 to the cycle of bt. There is no tick[1] on that base_tick, the next tick[1] arrives P base ticks later, and tick[0] is undisturbed.
- Run pause: drop run for 7 cycles mid-count. No pulses occur during the pause, and after resuming the remaining intervals complete exactly. Then assert reset during APPLY: all outputs are 0 the next cycle and the target channel is unprogrammed.

Source files
------------

// File: rtl/tick_scheduler_if.sv
// Configuration request/acknowledge bundle for tick_scheduler.
interface tick_scheduler_if #(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned PERIOD_W = 16
);
  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic                cfg_valid;
  logic                cfg_ready;
  logic [CH_W-1:0]     cfg_ch;
  logic [PERIOD_W-1:0] cfg_period;
  logic                cfg_en;
  logic                cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_period, cfg_en,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_period, cfg_en,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/tick_scheduler.sv
// Shared-prescaler tick scheduler: N_CH channels emit one-cycle enables at
// runtime-programmable multiples of a common base tick.
module tick_scheduler #(
  parameter int unsigned PRESCALE = 100,
  parameter int unsigned N_CH     = 4,
  parameter int unsigned PERIOD_W = 16
) (
  input  logic            clk_in,
  input  logic            reset,
  input  logic            run,
  tick_scheduler_if.slave cfg,
  output logic            base_tick,
  output logic [N_CH-1:0] tick
);
  localparam int unsigned     PC_W    = $clog2(PRESCALE);
  localparam int unsigned     CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PRESCALE - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } state_t;

  state_t state, state_next;

  logic [PC_W-1:0]     pcnt;
  logic                bt;
  logic [PERIOD_W-1:0] period [N_CH];
  logic [PERIOD_W-1:0] ccnt   [N_CH];
  logic [N_CH-1:0]     en;

  logic [CH_W-1:0]     lat_ch;
  logic [PERIOD_W-1:0] lat_period;
  logic                lat_en;
  logic                lat_bad_ch;

  logic                accept;
  logic                req_bad_ch;
  logic                req_bad;
  logic                ready_next;
  logic                err_next;
  logic [N_CH-1:0]     wr;
  logic [N_CH-1:0]     wrap;

  // Shared prescaler; configuration never touches it so channel phases stay aligned.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      pcnt <= '0;
    end else if (run) begin
      pcnt <= (pcnt == PC_LAST) ? '0 : pcnt + PC_W'(1);
    end
  end

  assign bt     = run && (pcnt == PC_LAST);
  assign accept = cfg.cfg_valid && cfg.cfg_ready;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = APPLY;
      APPLY:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_bad_ch = 32'(cfg.cfg_ch) >= 32'(N_CH);
    req_bad    = req_bad_ch || (cfg.cfg_period == '0);
    ready_next = (state_next == IDLE);
    err_next   = accept && req_bad;
  end

  // Handshake outputs and the request latched on acceptance.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      cfg.cfg_ready <= 1'b0;
      cfg.cfg_err   <= 1'b0;
      lat_ch        <= '0;
      lat_period    <= '0;
      lat_en        <= 1'b0;
      lat_bad_ch    <= 1'b0;
    end else begin
      cfg.cfg_ready <= ready_next;
      cfg.cfg_err   <= err_next;
      if (accept) begin
        lat_ch     <= cfg.cfg_ch;
        lat_period <= cfg.cfg_period;
        lat_en     <= cfg.cfg_en && (cfg.cfg_period != '0);
        lat_bad_ch <= req_bad_ch;
      end
    end
  end

  always_comb begin
    wr   = '0;
    wrap = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      wr[i]   = (state == APPLY) && !lat_bad_ch && (lat_ch == CH_W'(i));
      wrap[i] = (ccnt[i] == period[i] - PERIOD_W'(1));
    end
  end

  // Channel counters; a configuration write in the same cycle as bt wins.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      base_tick <= 1'b0;
      tick      <= '0;
      en        <= '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        period[i] <= '0;
        ccnt[i]   <= '0;
      end
    end else begin
      base_tick <= bt;
      for (int unsigned i = 0; i < N_CH; i++) begin
        tick[i] <= bt && en[i] && wrap[i] && !wr[i];
        if (wr[i]) begin
          period[i] <= lat_period;
          en[i]     <= lat_en;
          ccnt[i]   <= '0;
        end else if (bt && en[i]) begin
          ccnt[i] <= wrap[i] ? '0 : ccnt[i] + PERIOD_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_tick_scheduler.sv
// Scoreboard bench for tick_scheduler: expected pulses are queued as each
// edge is driven and retired when base_tick/tick appear.
module tb_tick_scheduler;
  localparam int PS       = 4;
  localparam int N_CH     = 5;
  localparam int PERIOD_W = 16;
  localparam int CH_W     = 3;

  logic            clk_in = 1'b0;
  logic            reset;
  logic            run;
  logic            base_tick;
  logic [N_CH-1:0] tick;

  tick_scheduler_if #(.N_CH(N_CH), .PERIOD_W(PERIOD_W)) cfg_if ();

  tick_scheduler #(.PRESCALE(PS), .N_CH(N_CH), .PERIOD_W(PERIOD_W)) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .run      (run),
    .cfg      (cfg_if),
    .base_tick(base_tick),
    .tick     (tick)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int              rc;
    logic [N_CH-1:0] mask;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   rc    = 0;
  int   cyc   = 0;
  int   m_rc[N_CH];
  int   m_p[N_CH];
  bit   m_on[N_CH];

  // Channel fires on every P-th base tick strictly after its APPLY edge.
  function automatic logic [N_CH-1:0] exp_mask(input int r);
    logic [N_CH-1:0] m;
    m = '0;
    for (int i = 0; i < N_CH; i++)
      if (m_on[i] && r > m_rc[i] && (((r - (m_rc[i] / PS) * PS) / PS) % m_p[i]) == 0)
        m[i] = 1'b1;
    return m;
  endfunction

  task automatic cycle();
    logic ran;
    exp_t e;
    ran = run && !reset;
    if (ran && ((rc + 1) % PS) == 0) begin
      e.rc   = rc + 1;
      e.mask = exp_mask(rc + 1);
      exp_q.push_back(e);
    end
    @(posedge clk_in);
    #1;
    cyc++;
    if (reset) begin
      rc = 0;
      exp_q.delete();
      for (int i = 0; i < N_CH; i++) begin
        m_on[i] = 1'b0;
        m_p[i]  = 0;
        m_rc[i] = 0;
      end
    end else if (ran) begin
      rc++;
    end
    if (base_tick || tick != '0) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse cyc=%0d rc=%0d base_tick=%b tick=%b required no pulse",
                 cyc, rc, base_tick, tick);
      end else begin
        e = exp_q.pop_front();
        if (e.rc != rc || base_tick !== 1'b1 || tick !== e.mask) begin
          bad++;
          $display("FAIL pulse cyc=%0d got rc=%0d base_tick=%b tick=%b required rc=%0d base_tick=1 tick=%b",
                   cyc, rc, base_tick, tick, e.rc, e.mask);
        end
      end
    end else if (exp_q.size() != 0 && exp_q[0].rc <= rc) begin
      total++;
      bad++;
      e = exp_q.pop_front();
      $display("FAIL missed_pulse cyc=%0d rc=%0d got no pulse required tick=%b", cyc, e.rc, e.mask);
    end
  endtask

  task automatic run_for(input int n);
    repeat (n) cycle();
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (cfg_if.cfg_ready !== 1'b1 && n < 10) begin
      cycle();
      n++;
    end
    total++;
    if (cfg_if.cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_timeout got cfg_ready=%b required 1", cfg_if.cfg_ready);
    end
  endtask

  task automatic cfg_write(input int ch, input int p, input bit en, input bit exp_err);
    wait_ready();
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_ch     = CH_W'(ch);
    cfg_if.cfg_period = PERIOD_W'(p);
    cfg_if.cfg_en     = en;
    cycle();
    cfg_if.cfg_valid = 1'b0;
    total++;
    if (cfg_if.cfg_ready !== 1'b0 || cfg_if.cfg_err !== exp_err) begin
      bad++;
      $display("FAIL cfg_apply_cycle ch=%0d got ready=%b err=%b required ready=0 err=%b",
               ch, cfg_if.cfg_ready, cfg_if.cfg_err, exp_err);
    end
    if (ch < N_CH && (p == 0 || !exp_err)) begin
      m_rc[ch] = rc + 1;
      m_p[ch]  = p;
      m_on[ch] = en && (p != 0);
    end
    cycle();
    total++;
    if (cfg_if.cfg_ready !== 1'b1 || cfg_if.cfg_err !== 1'b0) begin
      bad++;
      $display("FAIL cfg_after_apply ch=%0d got ready=%b err=%b required ready=1 err=0",
               ch, cfg_if.cfg_ready, cfg_if.cfg_err);
    end
  endtask

  task automatic check_quiet(input string name);
    total++;
    if (base_tick !== 1'b0 || tick !== '0 || cfg_if.cfg_ready !== 1'b0 || cfg_if.cfg_err !== 1'b0) begin
      bad++;
      $display("FAIL %s got base_tick=%b tick=%b ready=%b err=%b required all 0",
               name, base_tick, tick, cfg_if.cfg_ready, cfg_if.cfg_err);
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    run   = 1'b1;
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_ch     = '0;
    cfg_if.cfg_period = '0;
    cfg_if.cfg_en     = 1'b0;
    cycle();
    cycle();
    check_quiet("reset_values");
    reset = 1'b0;
    cycle();
    total++;
    if (cfg_if.cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_cycle1 got %b required 1", cfg_if.cfg_ready);
    end
    n = 0;
    while (rc < 13 && n < 40) begin
      cycle();
      n++;
    end
  endtask

  task automatic test_periods();
    cfg_write(0, 1, 1'b1, 1'b0);
    cfg_write(1, 3, 1'b1, 1'b0);
    run_for(60);
  endtask

  task automatic test_back_to_back();
    int per[4] = '{2, 1, 3, 4};
    wait_ready();
    cfg_if.cfg_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cfg_if.cfg_ch     = CH_W'(k);
      cfg_if.cfg_period = PERIOD_W'(per[k]);
      cfg_if.cfg_en     = 1'b1;
      total++;
      if (cfg_if.cfg_ready !== 1'b1) begin
        bad++;
        $display("FAIL b2b_ready_high req=%0d got %b required 1", k, cfg_if.cfg_ready);
      end
      cycle();
      total++;
      if (cfg_if.cfg_ready !== 1'b0 || cfg_if.cfg_err !== 1'b0) begin
        bad++;
        $display("FAIL b2b_ready_low req=%0d got ready=%b err=%b required ready=0 err=0",
                 k, cfg_if.cfg_ready, cfg_if.cfg_err);
      end
      m_rc[k] = rc + 1;
      m_p[k]  = per[k];
      m_on[k] = 1'b1;
      cycle();
    end
    cfg_if.cfg_valid = 1'b0;
    run_for(64);
  endtask

  task automatic test_invalid();
    cfg_write(2, 0, 1'b1, 1'b1);
    cfg_write(5, 3, 1'b1, 1'b1);
    cfg_write(7, 1, 1'b1, 1'b1);
    run_for(48);
  endtask

  task automatic test_collision();
    int n;
    n = 0;
    while (((rc % PS) != 2 || cfg_if.cfg_ready !== 1'b1) && n < 20) begin
      cycle();
      n++;
    end
    cfg_write(1, 2, 1'b1, 1'b0);
    total++;
    if ((rc % PS) != 0 || base_tick !== 1'b1 || tick[1] !== 1'b0 || tick[0] !== exp_mask(rc)[0]) begin
      bad++;
      $display("FAIL collision rc=%0d got base_tick=%b tick=%b required base_tick=1 tick[1]=0 at bt",
               rc, base_tick, tick);
    end
    run_for(40);
  endtask

  task automatic test_pause();
    run_for(6);
    run = 1'b0;
    for (int k = 0; k < 7; k++) begin
      cycle();
      total++;
      if (base_tick !== 1'b0 || tick !== '0) begin
        bad++;
        $display("FAIL pause_quiet k=%0d got base_tick=%b tick=%b required 0", k, base_tick, tick);
      end
    end
    run = 1'b1;
    run_for(48);
  endtask

  task automatic test_reset_apply();
    wait_ready();
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_ch     = CH_W'(4);
    cfg_if.cfg_period = PERIOD_W'(1);
    cfg_if.cfg_en     = 1'b1;
    cycle();
    cfg_if.cfg_valid = 1'b0;
    total++;
    if (cfg_if.cfg_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_apply_accept got ready=%b required 0", cfg_if.cfg_ready);
    end
    reset = 1'b1;
    cycle();
    check_quiet("reset_mid_apply");
    reset = 1'b0;
    run_for(30);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got no finish required finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_periods();
    test_back_to_back();
    test_invalid();
    test_collision();
    test_pause();
    test_reset_apply();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
